inst_fetch_ctrl: RTL and testbench

INST_FETCH_CTRL -- requirements
Module: inst_fetch_ctrl

---
 rtl/inst_fetch_ctrl.sv | 122 ++++++++++++
 tb/tb_inst_fetch_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch controller: PC sequencing, 2-entry FIFO to decode, and a
// round-robin arbiter sharing the single ROM read port with a debug reader.
module inst_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Clrn,
  output logic [31:0] MemAddr,
  input  logic [31:0] MemInst,
  output logic [31:0] Inst,
  output logic [31:0] InstPc,
  output logic        InstValid,
  input  logic        InstReady,
  input  logic        Redirect,
  input  logic [31:0] RedirectPc,
  input  logic        DbgReq,
  input  logic [31:0] DbgAddr,
  output logic        DbgGnt,
  output logic [31:0] DbgData,
  output logic        DbgValid
);

  localparam int unsigned DEPTH   = 2;
  localparam int unsigned CNT_W   = 2;
  localparam logic PRI_FETCH = 1'b0;
  localparam logic PRI_DBG   = 1'b1;

  logic [31:0]             pc_q, pc_d;
  logic [DEPTH-1:0][31:0]  buf_inst_q, buf_inst_d;
  logic [DEPTH-1:0][31:0]  buf_pc_q, buf_pc_d;
  logic                    head_q, head_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic                    pri_q, pri_d;
  logic [31:0]             dbg_data_q, dbg_data_d;
  logic                    dbg_valid_q, dbg_valid_d;

  logic fetch_req, dbg_gnt, fetch_gnt, push, pop, tail;
  logic unused_addr_bits;

  assign unused_addr_bits = ^{DbgAddr[1:0], RedirectPc[1:0]};

  // Arbitration and buffer control; fetch request depends only on registered count.
  always_comb begin
    fetch_req   = (count_q < CNT_W'(DEPTH));
    dbg_gnt     = DbgReq & (~fetch_req | (pri_q == PRI_DBG));
    fetch_gnt   = fetch_req & ~dbg_gnt;
    push        = fetch_gnt & ~Redirect;
    pop         = (count_q != '0) & InstReady & ~Redirect;
    tail        = head_q ^ count_q[0];

    pc_d        = pc_q;
    buf_inst_d  = buf_inst_q;
    buf_pc_d    = buf_pc_q;
    head_d      = head_q;
    count_d     = count_q;
    pri_d       = pri_q;
    dbg_data_d  = dbg_data_q;
    dbg_valid_d = dbg_gnt;

    if (dbg_gnt) begin
      pri_d      = PRI_FETCH;
      dbg_data_d = MemInst;
    end else if (fetch_gnt) begin
      pri_d = PRI_DBG;
    end

    if (push) begin
      buf_inst_d[tail] = MemInst;
      buf_pc_d[tail]   = pc_q;
      pc_d             = pc_q + 32'd4;
    end

    if (pop) begin
      head_d = ~head_q;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    // Redirect flushes the buffer; same-cycle fetch data and pop are dropped.
    if (Redirect) begin
      count_d = '0;
      pc_d    = {RedirectPc[31:2], 2'b00};
    end
  end

  always_ff @(posedge Clk) begin
    if (!Clrn) begin
      pc_q        <= {RESET_PC[31:2], 2'b00};
      head_q      <= 1'b0;
      count_q     <= '0;
      pri_q       <= PRI_FETCH;
      dbg_data_q  <= '0;
      dbg_valid_q <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      head_q      <= head_d;
      count_q     <= count_d;
      pri_q       <= pri_d;
      dbg_data_q  <= dbg_data_d;
      dbg_valid_q <= dbg_valid_d;
    end
  end

  // Buffer payload needs no reset; count gates its visibility.
  always_ff @(posedge Clk) begin
    buf_inst_q <= buf_inst_d;
    buf_pc_q   <= buf_pc_d;
  end

  assign MemAddr   = dbg_gnt ? {DbgAddr[31:2], 2'b00} : {pc_q[31:2], 2'b00};
  assign DbgGnt    = dbg_gnt;
  assign InstValid = (count_q != '0);
  assign Inst      = buf_inst_q[head_q];
  assign InstPc    = buf_pc_q[head_q];
  assign DbgData   = dbg_data_q;
  assign DbgValid  = dbg_valid_q;

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Directed self-checking bench for inst_fetch_ctrl; a second instance covers
// a non-zero reset PC that wraps past 2^32.
module tb_inst_fetch_ctrl;

  logic        clk = 1'b0;
  logic        clrn;
  logic        inst_ready, redirect, dbg_req;
  logic [31:0] redirect_pc, dbg_addr;

  logic [31:0] mem_addr, mem_inst, inst, inst_pc, dbg_data;
  logic        inst_valid, dbg_gnt, dbg_valid;

  logic [31:0] mem_addr2, mem_inst2, inst2, inst_pc2, dbg_data2;
  logic        inst_valid2, dbg_gnt2, dbg_valid2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return a ^ 32'hA5A5_5A5A;
  endfunction

  assign mem_inst  = rom(mem_addr);
  assign mem_inst2 = rom(mem_addr2);

  inst_fetch_ctrl dut (
    .Clk(clk), .Clrn(clrn), .MemAddr(mem_addr), .MemInst(mem_inst),
    .Inst(inst), .InstPc(inst_pc), .InstValid(inst_valid), .InstReady(inst_ready),
    .Redirect(redirect), .RedirectPc(redirect_pc), .DbgReq(dbg_req),
    .DbgAddr(dbg_addr), .DbgGnt(dbg_gnt), .DbgData(dbg_data), .DbgValid(dbg_valid)
  );

  inst_fetch_ctrl #(.RESET_PC(32'hFFFF_FFF8)) dut2 (
    .Clk(clk), .Clrn(clrn), .MemAddr(mem_addr2), .MemInst(mem_inst2),
    .Inst(inst2), .InstPc(inst_pc2), .InstValid(inst_valid2), .InstReady(inst_ready),
    .Redirect(redirect), .RedirectPc(redirect_pc), .DbgReq(1'b0),
    .DbgAddr(dbg_addr), .DbgGnt(dbg_gnt2), .DbgData(dbg_data2), .DbgValid(dbg_valid2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clrn = 1'b0; inst_ready = 1'b0; redirect = 1'b0; dbg_req = 1'b0;
    redirect_pc = '0; dbg_addr = '0;
    step();
    step();
    clrn = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL reset_inst_valid: got %b want 0", inst_valid); end
    checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset_mem_addr: got %h want 00000000", mem_addr); end
    checks++; if (dbg_valid !== 1'b0) begin errors++; $display("FAIL reset_dbg_valid: got %b want 0", dbg_valid); end
    checks++; if (dbg_data !== 32'h0) begin errors++; $display("FAIL reset_dbg_data: got %h want 0", dbg_data); end
    checks++; if (dbg_gnt !== 1'b0) begin errors++; $display("FAIL reset_dbg_gnt: got %b want 0", dbg_gnt); end
  endtask

  task automatic test_stream();
    do_reset();
    inst_ready = 1'b1;
    #1;
    for (int k = 1; k <= 5; k++) begin
      step();
      #1;
      checks++; if (mem_addr !== 32'(4 * k)) begin errors++; $display("FAIL stream_mem_addr[%0d]: got %h want %h", k, mem_addr, 32'(4 * k)); end
      checks++; if (inst_valid !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d]: got %b want 1", k, inst_valid); end
      checks++; if (inst_pc !== 32'(4 * (k - 1))) begin errors++; $display("FAIL stream_inst_pc[%0d]: got %h want %h", k, inst_pc, 32'(4 * (k - 1))); end
      checks++; if (inst !== rom(32'(4 * (k - 1)))) begin errors++; $display("FAIL stream_inst[%0d]: got %h want %h", k, inst, rom(32'(4 * (k - 1)))); end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    step(); step(); step();
    #1;
    checks++; if (mem_addr !== 32'h8) begin errors++; $display("FAIL bp_mem_addr_hold: got %h want 00000008", mem_addr); end
    checks++; if (inst_valid !== 1'b1) begin errors++; $display("FAIL bp_valid: got %b want 1", inst_valid); end
    inst_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #0;
      checks++; if (inst_pc !== 32'(4 * k)) begin errors++; $display("FAIL bp_order_pc[%0d]: got %h want %h", k, inst_pc, 32'(4 * k)); end
      checks++; if (inst !== rom(32'(4 * k))) begin errors++; $display("FAIL bp_order_inst[%0d]: got %h want %h", k, inst, rom(32'(4 * k))); end
      step();
      #1;
    end
    checks++; if (inst_pc !== 32'hC) begin errors++; $display("FAIL bp_after_pc: got %h want 0000000c", inst_pc); end
  endtask

  task automatic test_redirect();
    do_reset();
    step(); step();
    redirect = 1'b1; redirect_pc = 32'h43; inst_ready = 1'b1;
    #1;
    checks++; if (mem_addr !== 32'h8) begin errors++; $display("FAIL redir_full_addr: got %h want 00000008", mem_addr); end
    step();
    redirect = 1'b0; inst_ready = 1'b0;
    #1;
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL redir_flush_valid: got %b want 0", inst_valid); end
    checks++; if (mem_addr !== 32'h40) begin errors++; $display("FAIL redir_mem_addr: got %h want 00000040", mem_addr); end
    step();
    #1;
    checks++; if (inst_valid !== 1'b1) begin errors++; $display("FAIL redir_valid: got %b want 1", inst_valid); end
    checks++; if (inst_pc !== 32'h40) begin errors++; $display("FAIL redir_inst_pc: got %h want 00000040", inst_pc); end
    checks++; if (inst !== rom(32'h40)) begin errors++; $display("FAIL redir_inst: got %h want %h", inst, rom(32'h40)); end
    step();
    #1;
    checks++; if (inst_pc !== 32'h40) begin errors++; $display("FAIL redir_head_hold: got %h want 00000040", inst_pc); end
  endtask

  task automatic test_debug();
    do_reset();
    inst_ready = 1'b1; dbg_req = 1'b1; dbg_addr = 32'h0E;
    #1;
    checks++; if (dbg_gnt !== 1'b0) begin errors++; $display("FAIL dbg_first_gnt: got %b want 0", dbg_gnt); end
    for (int k = 1; k <= 6; k++) begin
      step();
      #1;
      checks++; if (dbg_gnt !== k[0]) begin errors++; $display("FAIL dbg_gnt[%0d]: got %b want %b", k, dbg_gnt, k[0]); end
      if (k[0]) begin
        checks++; if (mem_addr !== 32'h0C) begin errors++; $display("FAIL dbg_mem_addr[%0d]: got %h want 0000000c", k, mem_addr); end
      end
      checks++; if (dbg_valid !== ~k[0]) begin errors++; $display("FAIL dbg_valid[%0d]: got %b want %b", k, dbg_valid, ~k[0]); end
      if (!k[0]) begin
        checks++; if (dbg_data !== rom(32'h0C)) begin errors++; $display("FAIL dbg_data[%0d]: got %h want %h", k, dbg_data, rom(32'h0C)); end
      end
    end
    dbg_req = 1'b0;
    step();
    #1;
    checks++; if (dbg_gnt !== 1'b0) begin errors++; $display("FAIL dbg_idle_gnt: got %b want 0", dbg_gnt); end
    checks++; if (dbg_valid !== 1'b0) begin errors++; $display("FAIL dbg_idle_valid: got %b want 0", dbg_valid); end
    checks++; if (dbg_data !== rom(32'h0C)) begin errors++; $display("FAIL dbg_data_hold: got %h want %h", dbg_data, rom(32'h0C)); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    step(); step();
    dbg_req = 1'b1; dbg_addr = 32'h20;
    #1;
    checks++; if (dbg_gnt !== 1'b1) begin errors++; $display("FAIL mid_full_gnt: got %b want 1", dbg_gnt); end
    step();
    #1;
    checks++; if (dbg_data !== rom(32'h20)) begin errors++; $display("FAIL mid_dbg_data: got %h want %h", dbg_data, rom(32'h20)); end
    clrn = 1'b0; redirect = 1'b1; redirect_pc = 32'h100; inst_ready = 1'b1;
    step();
    clrn = 1'b1; redirect = 1'b0; inst_ready = 1'b0;
    #1;
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL mid_inst_valid: got %b want 0", inst_valid); end
    checks++; if (dbg_valid !== 1'b0) begin errors++; $display("FAIL mid_dbg_valid: got %b want 0", dbg_valid); end
    checks++; if (dbg_data !== 32'h0) begin errors++; $display("FAIL mid_dbg_data_clr: got %h want 0", dbg_data); end
    checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL mid_mem_addr: got %h want 00000000", mem_addr); end
    checks++; if (dbg_gnt !== 1'b0) begin errors++; $display("FAIL mid_dbg_gnt: got %b want 0", dbg_gnt); end
    step();
    #1;
    checks++; if (dbg_valid !== 1'b0) begin errors++; $display("FAIL mid_no_pulse: got %b want 0", dbg_valid); end
    dbg_req = 1'b0;
  endtask

  task automatic test_wrap();
    logic [31:0] exp_pc;
    do_reset();
    inst_ready = 1'b1;
    #1;
    checks++; if (mem_addr2 !== 32'hFFFF_FFF8) begin errors++; $display("FAIL wrap_reset_addr: got %h want fffffff8", mem_addr2); end
    exp_pc = 32'hFFFF_FFF8;
    for (int k = 1; k <= 3; k++) begin
      step();
      #1;
      checks++; if (inst_pc2 !== exp_pc) begin errors++; $display("FAIL wrap_inst_pc[%0d]: got %h want %h", k, inst_pc2, exp_pc); end
      checks++; if (inst2 !== rom(exp_pc)) begin errors++; $display("FAIL wrap_inst[%0d]: got %h want %h", k, inst2, rom(exp_pc)); end
      exp_pc = exp_pc + 32'd4;
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_debug();
    test_reset_mid();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
